// File: rtl/segre_pkg.sv
// Shared core types: memory access sizes, arbiter states/owners and bus geometry.
package segre_pkg;

  localparam int ADDR_SIZE             = 32;
  localparam int CACHE_LINE_SIZE_BYTES = 16;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_MEM  = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/segre_mem_arbiter.sv
// Shares the single external memory port between IF line fetches and MEM loads/stores.
// Define SEGRE_ARB_RR_EN for round-robin on collisions; default is fixed MEM-over-IF priority.
module segre_mem_arbiter
  import segre_pkg::memop_data_type_e;
#(
  parameter int ADDR_SIZE             = segre_pkg::ADDR_SIZE,
  parameter int CACHE_LINE_SIZE_BYTES = segre_pkg::CACHE_LINE_SIZE_BYTES
) (
  input  logic                               clk_i,
  input  logic                               rsn_i,
  input  logic                               if_rd_i,
  input  logic [ADDR_SIZE-1:0]               if_addr_i,
  output logic                               if_ready_o,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0] if_rd_data_o,
  input  logic                               dmem_rd_i,
  input  logic                               dmem_wr_i,
  input  logic [ADDR_SIZE-1:0]               dmem_addr_i,
  input  memop_data_type_e                   dmem_type_i,
  input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] dmem_wr_data_i,
  output logic                               dmem_ready_o,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0] dmem_rd_data_o,
  output logic [ADDR_SIZE-1:0]               addr_o,
  output logic                               mem_rd_o,
  output logic                               mem_wr_o,
  output memop_data_type_e                   mem_data_type_o,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_wr_data_o,
  input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_rd_data_i,
  input  logic                               mem_ready_i
);

  import segre_pkg::*;

  arb_state_e state_reg;
  logic       mem_req;
  logic       if_wins;

  assign mem_req = dmem_rd_i | dmem_wr_i;

`ifdef SEGRE_ARB_RR_EN
  arb_owner_e last_grant_reg;

  // On a collision the side that was not served last time takes the port.
  assign if_wins = if_rd_i & (~mem_req | (last_grant_reg == OWNER_MEM));

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      last_grant_reg <= OWNER_IF;
    end else if (state_reg == ARB_IDLE) begin
      if (if_wins) begin
        last_grant_reg <= OWNER_IF;
      end else if (mem_req) begin
        last_grant_reg <= OWNER_MEM;
      end
    end
  end
`else
  // MEM holds the older instruction, so it always wins to avoid a pipeline deadlock.
  assign if_wins = if_rd_i & ~mem_req;
`endif

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_reg       <= ARB_IDLE;
      addr_o          <= '0;
      mem_rd_o        <= 1'b0;
      mem_wr_o        <= 1'b0;
      mem_data_type_o <= WORD;
      mem_wr_data_o   <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (if_wins) begin
            state_reg       <= ARB_IF;
            addr_o          <= if_addr_i;
            mem_rd_o        <= 1'b1;
            mem_wr_o        <= 1'b0;
            mem_data_type_o <= WORD;
            mem_wr_data_o   <= '0;
          end else if (mem_req) begin
            // A simultaneous load and store strobe resolves to a store.
            state_reg       <= ARB_MEM;
            addr_o          <= dmem_addr_i;
            mem_rd_o        <= dmem_rd_i & ~dmem_wr_i;
            mem_wr_o        <= dmem_wr_i;
            mem_data_type_o <= dmem_type_i;
            mem_wr_data_o   <= dmem_wr_data_i;
          end
        end
        ARB_IF, ARB_MEM: begin
          if (mem_ready_i) begin
            state_reg <= ARB_IDLE;
            mem_rd_o  <= 1'b0;
            mem_wr_o  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ARB_IDLE;
          mem_rd_o  <= 1'b0;
          mem_wr_o  <= 1'b0;
        end
      endcase
    end
  end

  assign if_ready_o   = (state_reg == ARB_IF) & mem_ready_i;
  assign dmem_ready_o = (state_reg == ARB_MEM) & mem_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < CACHE_LINE_SIZE_BYTES; gi++) begin : g_rd_lane
      assign if_rd_data_o[gi*8 +: 8]   = mem_rd_data_i[gi*8 +: 8] & {8{if_ready_o}};
      assign dmem_rd_data_o[gi*8 +: 8] = mem_rd_data_i[gi*8 +: 8] & {8{dmem_ready_o}};
    end
  endgenerate

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed scoreboard bench for segre_mem_arbiter; follows SEGRE_ARB_RR_EN like the design.
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  localparam int LW = CACHE_LINE_SIZE_BYTES * 8;

  logic                 clk_i = 1'b0;
  logic                 rsn_i;
  logic                 if_rd_i;
  logic [ADDR_SIZE-1:0] if_addr_i;
  logic                 if_ready_o;
  logic [LW-1:0]        if_rd_data_o;
  logic                 dmem_rd_i;
  logic                 dmem_wr_i;
  logic [ADDR_SIZE-1:0] dmem_addr_i;
  memop_data_type_e     dmem_type_i;
  logic [LW-1:0]        dmem_wr_data_i;
  logic                 dmem_ready_o;
  logic [LW-1:0]        dmem_rd_data_o;
  logic [ADDR_SIZE-1:0] addr_o;
  logic                 mem_rd_o;
  logic                 mem_wr_o;
  memop_data_type_e     mem_data_type_o;
  logic [LW-1:0]        mem_wr_data_o;
  logic [LW-1:0]        mem_rd_data_i;
  logic                 mem_ready_i;

  segre_mem_arbiter dut (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .if_rd_i        (if_rd_i),
    .if_addr_i      (if_addr_i),
    .if_ready_o     (if_ready_o),
    .if_rd_data_o   (if_rd_data_o),
    .dmem_rd_i      (dmem_rd_i),
    .dmem_wr_i      (dmem_wr_i),
    .dmem_addr_i    (dmem_addr_i),
    .dmem_type_i    (dmem_type_i),
    .dmem_wr_data_i (dmem_wr_data_i),
    .dmem_ready_o   (dmem_ready_o),
    .dmem_rd_data_o (dmem_rd_data_o),
    .addr_o         (addr_o),
    .mem_rd_o       (mem_rd_o),
    .mem_wr_o       (mem_wr_o),
    .mem_data_type_o(mem_data_type_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_rd_data_i  (mem_rd_data_i),
    .mem_ready_i    (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit                   is_if;
    logic [ADDR_SIZE-1:0] addr;
    logic                 rd;
    logic                 wr;
    memop_data_type_e     dtype;
    logic [LW-1:0]        wdata;
  } txn_t;

  txn_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   if_pulses = 0;
  int   dmem_pulses = 0;
  int   exp_if_pulses = 0;
  int   exp_dmem_pulses = 0;

  always @(posedge clk_i) begin
    if (if_ready_o)   if_pulses   <= if_pulses + 1;
    if (dmem_ready_o) dmem_pulses <= dmem_pulses + 1;
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input bit is_if, input logic [ADDR_SIZE-1:0] a, input logic rd,
                              input logic wr, input memop_data_type_e ty, input logic [LW-1:0] wd);
    txn_t t;
    t.is_if = is_if; t.addr = a; t.rd = rd; t.wr = wr; t.dtype = ty; t.wdata = wd;
    return t;
  endfunction

  // Acts as the memory: waits for a strobe, holds ready off for lat-1 cycles,
  // completes on cycle lat and checks the transaction against the scoreboard head.
  task automatic serve(input int lat, input logic [LW-1:0] line, input bit drop, input bit chg);
    txn_t t;
    int   waited = 0;
    tick();
    while (!(mem_rd_o | mem_wr_o) && waited < 20) begin
      tick();
      waited++;
    end
    check("strobe_seen", 128'(mem_rd_o | mem_wr_o), 128'(1));
    if (!(mem_rd_o | mem_wr_o)) return;
    check("sb_nonempty", 128'(sb_q.size() > 0), 128'(1));
    if (sb_q.size() == 0) return;
    t = sb_q.pop_front();
    for (int c = 1; c <= lat; c++) begin
      check("addr_o", 128'(addr_o), 128'(t.addr));
      check("mem_rd_o", 128'(mem_rd_o), 128'(t.rd));
      check("mem_wr_o", 128'(mem_wr_o), 128'(t.wr));
      check("mem_type", 128'(mem_data_type_o), 128'(t.dtype));
      check("mem_wdata", 128'(mem_wr_data_o), 128'(t.wdata));
      if (c == 1 && chg) if_addr_i = 32'h200;
      if (c == lat) begin
        mem_ready_i   = 1'b1;
        mem_rd_data_i = line;
        #1;
        check("if_ready", 128'(if_ready_o), 128'(t.is_if));
        check("dmem_ready", 128'(dmem_ready_o), 128'(!t.is_if));
        check("if_rd_data", 128'(if_rd_data_o), t.is_if ? 128'(line) : 128'(0));
        check("dmem_rd_data", 128'(dmem_rd_data_o), t.is_if ? 128'(0) : 128'(line));
      end else begin
        check("early_ready", 128'(if_ready_o | dmem_ready_o), 128'(0));
        tick();
      end
    end
    if (t.is_if) exp_if_pulses++;
    else exp_dmem_pulses++;
    tick();
    mem_ready_i   = 1'b0;
    mem_rd_data_i = '0;
    if (drop) begin
      if (t.is_if) if_rd_i = 1'b0;
      else begin
        dmem_rd_i = 1'b0;
        dmem_wr_i = 1'b0;
      end
    end
    check("gap_rd", 128'(mem_rd_o), 128'(0));
    check("gap_wr", 128'(mem_wr_o), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsn_i = 1'b0; if_rd_i = 1'b0; if_addr_i = '0;
    dmem_rd_i = 1'b0; dmem_wr_i = 1'b0; dmem_addr_i = '0;
    dmem_type_i = WORD; dmem_wr_data_i = '0;
    mem_rd_data_i = '0; mem_ready_i = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_rd", 128'(mem_rd_o), 128'(0));
    check("rst_wr", 128'(mem_wr_o), 128'(0));
    check("rst_addr", 128'(addr_o), 128'(0));
    check("rst_type", 128'(mem_data_type_o), 128'(WORD));
    check("rst_wdata", 128'(mem_wr_data_o), 128'(0));
    check("rst_ready", 128'({if_ready_o, dmem_ready_o}), 128'(0));
    rsn_i = 1'b1;
    tick();

    // 1: IF fetch alone, memory answers on the third cycle
    if_rd_i = 1'b1; if_addr_i = 32'h100;
    sb_q.push_back(mk(1'b1, 32'h100, 1'b1, 1'b0, WORD, '0));
    serve(3, {4{32'hCAFE_0001}}, 1'b1, 1'b0);
    $display("txn IF-only addr=100 done");

    // 2: simultaneous IF and MEM load, MEM served first
    if_rd_i = 1'b1; if_addr_i = 32'h100;
    dmem_rd_i = 1'b1; dmem_addr_i = 32'h2000; dmem_type_i = WORD;
    sb_q.push_back(mk(1'b0, 32'h2000, 1'b1, 1'b0, WORD, '0));
    sb_q.push_back(mk(1'b1, 32'h100, 1'b1, 1'b0, WORD, '0));
    serve(2, {4{32'h1111_2222}}, 1'b1, 1'b0);
    serve(1, {4{32'h3333_4444}}, 1'b1, 1'b0);
    check("pulses_if", 128'(if_pulses), 128'(exp_if_pulses));
    check("pulses_dmem", 128'(dmem_pulses), 128'(exp_dmem_pulses));
    $display("txn collision MEM=2000 then IF=100 done");

    // 3: byte store, read strobe dropped even with load also raised
    dmem_wr_i = 1'b1; dmem_rd_i = 1'b1; dmem_addr_i = 32'h40; dmem_type_i = BYTE;
    dmem_wr_data_i = {16{8'hAB}};
    sb_q.push_back(mk(1'b0, 32'h40, 1'b0, 1'b1, BYTE, {16{8'hAB}}));
    serve(2, {4{32'h5555_6666}}, 1'b1, 1'b0);
    $display("txn store addr=40 done");

    // 4: requester address changes mid-transaction
    if_rd_i = 1'b1; if_addr_i = 32'h100;
    sb_q.push_back(mk(1'b1, 32'h100, 1'b1, 1'b0, WORD, '0));
    serve(4, {4{32'h7777_8888}}, 1'b1, 1'b1);
    $display("txn IF stability addr=100 done");

    // 5: reset while MEM owns the port, stray mem_ready in idle
    dmem_rd_i = 1'b1; dmem_addr_i = 32'h3000; dmem_type_i = WORD; dmem_wr_data_i = '0;
    tick();
    check("r5_busy", 128'(mem_rd_o), 128'(1));
    rsn_i = 1'b0;
    tick();
    check("r5_rd", 128'(mem_rd_o), 128'(0));
    check("r5_wr", 128'(mem_wr_o), 128'(0));
    check("r5_addr", 128'(addr_o), 128'(0));
    rsn_i = 1'b1; dmem_rd_i = 1'b0; mem_ready_i = 1'b1;
    #1;
    check("r5_idle_ready", 128'({if_ready_o, dmem_ready_o}), 128'(0));
    tick();
    mem_ready_i = 1'b0;
    check("r5_no_grant", 128'(mem_rd_o | mem_wr_o), 128'(0));
    check("r5_pulses_dmem", 128'(dmem_pulses), 128'(exp_dmem_pulses));
    if_rd_i = 1'b1; if_addr_i = 32'h100;
    sb_q.push_back(mk(1'b1, 32'h100, 1'b1, 1'b0, WORD, '0));
    serve(2, {4{32'h9999_AAAA}}, 1'b1, 1'b0);
    $display("txn reset recovery IF addr=100 done");

    // 6: both sides request continuously
    if_rd_i = 1'b1; if_addr_i = 32'h600;
    dmem_rd_i = 1'b1; dmem_addr_i = 32'h500; dmem_type_i = WORD;
    for (int k = 0; k < 4; k++) begin
`ifdef SEGRE_ARB_RR_EN
      if (k % 2 == 1) sb_q.push_back(mk(1'b1, 32'h600, 1'b1, 1'b0, WORD, '0));
      else            sb_q.push_back(mk(1'b0, 32'h500, 1'b1, 1'b0, WORD, '0));
`else
      sb_q.push_back(mk(1'b0, 32'h500, 1'b1, 1'b0, WORD, '0));
`endif
      serve(1 + k, {4{32'hB000_0000 + 32'(k)}}, 1'b0, 1'b0);
      $display("txn continuous grant %0d done", k);
    end
    if_rd_i = 1'b0; dmem_rd_i = 1'b0;
    tick(); tick();
    check("c6_quiet", 128'(mem_rd_o | mem_wr_o), 128'(0));
    check("c6_pulses_if", 128'(if_pulses), 128'(exp_if_pulses));
    check("c6_pulses_dmem", 128'(dmem_pulses), 128'(exp_dmem_pulses));
    check("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
